// File: rtl/demux16_dispatch.sv
// 1-to-16 valid/ready stream demultiplexer with a one-entry holding slot per lane.
// Optional stall statistics counter enabled by defining DEMUX16_STATS_EN.
module demux16_dispatch #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [3:0]               in_sel,
  input  logic [DATA_WIDTH-1:0]    in_data,
  output logic [15:0]              out_valid,
  input  logic [15:0]              out_ready,
`ifdef DEMUX16_STATS_EN
  output logic [31:0]              stall_cnt,
`endif
  output logic [16*DATA_WIDTH-1:0] out_data
);

  logic [15:0]           valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q [16];
  logic [DATA_WIDTH-1:0] data_d [16];
  logic                  accept;

  // Input handshake: only the selected lane's occupancy and consumer matter.
  always_comb begin
    in_ready = ~valid_q[in_sel] | out_ready[in_sel];
    accept   = in_valid & in_ready;
  end

  // Per-lane slot next state: drain clears, an accept for the lane reloads.
  always_comb begin
    valid_d = valid_q;
    for (int k = 0; k < 16; k++) begin
      data_d[k] = data_q[k];
      if (valid_q[k] && out_ready[k]) begin
        valid_d[k] = 1'b0;
      end
      if (accept && (in_sel == 4'(k))) begin
        valid_d[k] = 1'b1;
        data_d[k]  = in_data;
      end
    end
  end

  // Slot registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int k = 0; k < 16; k++) begin
        data_q[k] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      for (int k = 0; k < 16; k++) begin
        data_q[k] <= data_d[k];
      end
    end
  end

  // Flatten lane slots onto the output bus.
  always_comb begin
    out_valid = valid_q;
    out_data  = '0;
    for (int k = 0; k < 16; k++) begin
      out_data[k*DATA_WIDTH +: DATA_WIDTH] = data_q[k];
    end
  end

`ifdef DEMUX16_STATS_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Count cycles where the producer is held off; saturate rather than wrap.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (in_valid && !in_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  // Statistics disabled: no counter, datapath unchanged.
`endif

endmodule
